// File: rtl/blackjack_round_ctrl.sv
// Round sequencer for the blackjack datapath: deal, player turn, dealer play and
// outcome resolution, drawing cards from the card source over a req/valid handshake.
module blackjack_round_ctrl #(
    parameter int DEALER_STAND = 17,
    parameter int CARD_W       = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              HIT,
    input  logic              STAND,
    input  logic              card_valid,
    input  logic [CARD_W-1:0] card_val,
    output logic              card_req,
    output logic [4:0]        player_total,
    output logic [4:0]        dealer_total,
    output logic [3:0]        player_cards,
    output logic [3:0]        state_code,
    output logic              busy,
    output logic              win,
    output logic              lose,
    output logic              push
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DEAL_P1 = 4'd1,
        DEAL_D1 = 4'd2,
        DEAL_P2 = 4'd3,
        DEAL_D2 = 4'd4,
        PLAYER  = 4'd5,
        P_HIT   = 4'd6,
        DEALER  = 4'd7,
        D_HIT   = 4'd8,
        RESULT  = 4'd9
    } state_t;

    localparam logic [4:0] STAND_T = 5'(DEALER_STAND);

    state_t     state, state_next;
    logic [4:0] p_hard, d_hard;
    logic       p_ace, d_ace;
    logic [3:0] p_cards;
    logic       card_req_next, win_next, lose_next, push_next, clear;

    logic       accept;
    logic [4:0] card_pts;
    logic [4:0] p_hard_add, d_hard_add;
    logic       p_ace_add, d_ace_add;
    logic [4:0] p_best, d_best, p_best_add;

    function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[5] ? 5'd31 : s[4:0];
    endfunction

    // An ace counts as 11 only while that cannot bust the hand.
    function automatic logic [4:0] best_of(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction

    function automatic logic is_draw(input state_t s);
        return s inside {DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, P_HIT, D_HIT};
    endfunction

    assign accept     = card_req && card_valid;
    assign card_pts   = (card_val == '0 || card_val > CARD_W'(10)) ? 5'd10 : 5'(card_val);
    assign p_hard_add = sat_add(p_hard, card_pts);
    assign d_hard_add = sat_add(d_hard, card_pts);
    assign p_ace_add  = p_ace || (card_pts == 5'd1);
    assign d_ace_add  = d_ace || (card_pts == 5'd1);
    assign p_best     = best_of(p_hard, p_ace);
    assign d_best     = best_of(d_hard, d_ace);
    assign p_best_add = best_of(p_hard_add, p_ace_add);

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        win_next   = win;
        lose_next  = lose;
        push_next  = push;
        case (state)
            IDLE, RESULT: begin
                if (START) begin
                    clear      = 1'b1;
                    win_next   = 1'b0;
                    lose_next  = 1'b0;
                    push_next  = 1'b0;
                    state_next = DEAL_P1;
                end
            end
            DEAL_P1: if (accept) state_next = DEAL_D1;
            DEAL_D1: if (accept) state_next = DEAL_P2;
            DEAL_P2: if (accept) state_next = DEAL_D2;
            DEAL_D2: if (accept) state_next = PLAYER;
            PLAYER: begin
                if (p_best == 5'd21 || STAND) state_next = DEALER;
                else if (HIT)                 state_next = P_HIT;
            end
            // Decide on the freshly accepted card so a bust skips the dealer entirely.
            P_HIT: begin
                if (accept) begin
                    if (p_hard_add > 5'd21) begin
                        state_next = RESULT;
                        win_next   = 1'b0;
                        lose_next  = 1'b1;
                        push_next  = 1'b0;
                    end else if (p_best_add == 5'd21) begin
                        state_next = DEALER;
                    end else begin
                        state_next = PLAYER;
                    end
                end
            end
            DEALER: begin
                if (d_best >= STAND_T || d_hard > 5'd21) begin
                    state_next = RESULT;
                    win_next   = (d_hard > 5'd21) || (p_best > d_best);
                    lose_next  = (d_hard <= 5'd21) && (p_best < d_best);
                    push_next  = (d_hard <= 5'd21) && (p_best == d_best);
                end else begin
                    state_next = D_HIT;
                end
            end
            D_HIT:   if (accept) state_next = DEALER;
            default: state_next = IDLE;
        endcase
        card_req_next = is_draw(state_next) && !accept;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            card_req <= 1'b0;
            p_hard   <= '0;
            d_hard   <= '0;
            p_ace    <= 1'b0;
            d_ace    <= 1'b0;
            p_cards  <= '0;
            win      <= 1'b0;
            lose     <= 1'b0;
            push     <= 1'b0;
        end else begin
            state    <= state_next;
            card_req <= card_req_next;
            win      <= win_next;
            lose     <= lose_next;
            push     <= push_next;
            if (clear) begin
                p_hard  <= '0;
                d_hard  <= '0;
                p_ace   <= 1'b0;
                d_ace   <= 1'b0;
                p_cards <= '0;
            end else if (accept) begin
                if (state inside {DEAL_P1, DEAL_P2, P_HIT}) begin
                    p_hard <= p_hard_add;
                    p_ace  <= p_ace_add;
                    if (p_cards != 4'd15) p_cards <= p_cards + 4'd1;
                end else begin
                    d_hard <= d_hard_add;
                    d_ace  <= d_ace_add;
                end
            end
        end
    end

    assign player_total = p_best;
    assign dealer_total = d_best;
    assign player_cards = p_cards;
    assign state_code   = state;
    assign busy         = !(state == IDLE || state == RESULT);

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed self-checking bench for blackjack_round_ctrl with hand-computed hands.
module tb_blackjack_round_ctrl;

    logic       CLK = 1'b0;
    logic       RST, START, HIT, STAND, card_valid;
    logic [3:0] card_val;
    logic       card_req, busy, win, lose, push;
    logic [4:0] player_total, dealer_total;
    logic [3:0] player_cards, state_code;

    int total_checks = 0;
    int bad_checks   = 0;

    blackjack_round_ctrl #(.DEALER_STAND(17), .CARD_W(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .HIT(HIT), .STAND(STAND),
        .card_valid(card_valid), .card_val(card_val), .card_req(card_req),
        .player_total(player_total), .dealer_total(dealer_total),
        .player_cards(player_cards), .state_code(state_code), .busy(busy),
        .win(win), .lose(lose), .push(push)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total_checks++;
        if (obs != exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle pulse on the button inputs, returning just after the edge that sees it.
    task automatic applyStimulus(input logic s, input logic h, input logic t);
        START = s; HIT = h; STAND = t;
        @(posedge CLK); #1;
        START = 1'b0; HIT = 1'b0; STAND = 1'b0;
    endtask

    task automatic deal_card(input logic [3:0] v);
        int n = 0;
        while (!card_req && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!card_req) checkOutput("card_req_timeout", card_req, 1);
        card_valid = 1'b1;
        card_val   = v;
        @(posedge CLK); #1;
        card_valid = 1'b0;
    endtask

    task automatic deal4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        deal_card(a); deal_card(b); deal_card(c); deal_card(d);
    endtask

    task automatic wait_state(input string tag, input logic [3:0] code);
        int n = 0;
        while (state_code != code && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        checkOutput(tag, state_code, code);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; HIT = 1'b0; STAND = 1'b0;
        card_valid = 1'b0; card_val = 4'd0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_state", state_code, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req", card_req, 0);
        RST = 1'b0;

        // Win by standing on 19 against a dealer 17 that draws nothing.
        applyStimulus(1, 0, 0);
        checkOutput("deal_busy", busy, 1);
        deal4(10, 7, 9, 10);
        checkOutput("t1_state", state_code, 5);
        checkOutput("t1_ptot", player_total, 19);
        checkOutput("t1_dtot", dealer_total, 17);
        applyStimulus(0, 0, 1);
        wait_state("t1_result", 9);
        checkOutput("t1_win", win, 1);
        checkOutput("t1_lose", lose, 0);
        checkOutput("t1_push", push, 0);
        checkOutput("t1_dtot_end", dealer_total, 17);
        checkOutput("t1_pcards", player_cards, 2);
        checkOutput("t1_busy", busy, 0);

        // Player busts on a hit; dealer must not draw.
        applyStimulus(1, 0, 0);
        checkOutput("t2_clear_win", win, 0);
        checkOutput("t2_clear_ptot", player_total, 0);
        deal4(10, 5, 6, 10);
        applyStimulus(0, 1, 0);
        checkOutput("t2_phit", state_code, 6);
        deal_card(9);
        checkOutput("t2_state", state_code, 9);
        checkOutput("t2_ptot", player_total, 25);
        checkOutput("t2_lose", lose, 1);
        checkOutput("t2_win", win, 0);
        checkOutput("t2_dtot", dealer_total, 15);
        checkOutput("t2_pcards", player_cards, 3);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("t2_noreq", card_req, 0);

        // Natural 21 moves on without STAND.
        applyStimulus(1, 0, 0);
        deal4(1, 9, 10, 8);
        checkOutput("t3_ptot", player_total, 21);
        wait_state("t3_result", 9);
        checkOutput("t3_win", win, 1);
        checkOutput("t3_dtot", dealer_total, 17);

        // Soft 17 dealer stands; push on 17.
        applyStimulus(1, 0, 0);
        deal4(10, 1, 7, 6);
        checkOutput("t4_dtot", dealer_total, 17);
        applyStimulus(0, 0, 1);
        wait_state("t4_result", 9);
        checkOutput("t4_push", push, 1);
        checkOutput("t4_win", win, 0);
        checkOutput("t4_lose", lose, 0);

        // Soft 16 hits a 10 and becomes hard 16, then loses to 18.
        applyStimulus(1, 0, 0);
        deal4(1, 10, 5, 8);
        checkOutput("t5_soft", player_total, 16);
        applyStimulus(0, 1, 0);
        deal_card(10);
        checkOutput("t5_state", state_code, 5);
        checkOutput("t5_hard", player_total, 16);
        applyStimulus(0, 0, 1);
        wait_state("t5_result", 9);
        checkOutput("t5_lose", lose, 1);

        // Handshake stall, ignored valid, ignored START, HIT+STAND, dealer bust.
        applyStimulus(1, 0, 0);
        deal_card(10);
        deal_card(5);
        checkOutput("t6_gap_req", card_req, 0);
        card_valid = 1'b1; card_val = 4'd5;
        @(posedge CLK); #1;
        card_valid = 1'b0;
        checkOutput("t6_ignored", player_total, 10);
        repeat (20) @(posedge CLK);
        #1;
        checkOutput("t6_hold_state", state_code, 3);
        checkOutput("t6_hold_req", card_req, 1);
        deal_card(6);
        deal_card(2);
        checkOutput("t6_ptot", player_total, 16);
        applyStimulus(1, 0, 0);
        checkOutput("t6_start_ign", state_code, 5);
        checkOutput("t6_start_dtot", dealer_total, 7);
        applyStimulus(0, 1, 1);
        checkOutput("t6_hitstand", state_code, 7);
        deal_card(5);
        deal_card(10);
        wait_state("t6_result", 9);
        checkOutput("t6_dtot", dealer_total, 22);
        checkOutput("t6_win", win, 1);

        // Reset while the dealer is mid-handshake discards the card.
        applyStimulus(1, 0, 0);
        deal4(10, 5, 7, 6);
        applyStimulus(0, 0, 1);
        wait_state("t7_dhit", 8);
        checkOutput("t7_req", card_req, 1);
        card_valid = 1'b1; card_val = 4'd10; RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; card_valid = 1'b0;
        checkOutput("t7_state", state_code, 0);
        checkOutput("t7_req0", card_req, 0);
        checkOutput("t7_ptot", player_total, 0);
        checkOutput("t7_dtot", dealer_total, 0);
        checkOutput("t7_pcards", player_cards, 0);
        checkOutput("t7_flags", {win, lose, push}, 0);
        @(posedge CLK); #1;
        checkOutput("t7_idle_hold", state_code, 0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
